// File: rtl/puf_response_collector.sv
// Sequencer for a pair of ring-oscillator counters. It walks RESP_BITS RO pairs, compares
// each pair's captured counts into one response bit, and hands the word off over valid/ready.
module puf_response_collector #(
  parameter int  CNT_W       = 8,
  parameter int  RESP_BITS   = 8,
  parameter int  CLR_CYC     = 2,
  parameter int  TIMEOUT_CYC = 4096,
  localparam int IDX_W       = $clog2(RESP_BITS),
  localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1),
  localparam int TIE_W       = $clog2(RESP_BITS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     cnt_a_i,
  input  logic [CNT_W-1:0]     cnt_b_i,
  input  logic                 fin_a_i,
  input  logic                 fin_b_i,
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  output logic [IDX_W-1:0]     sel_idx_o,
  output logic                 busy_o,
  output logic [RESP_BITS-1:0] resp_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [TIE_W-1:0]     tie_cnt_o,
  output logic                 err_o
);

  localparam int CLR_W = $clog2(CLR_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_COMPARE, S_NEXT, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [TIE_W-1:0]     tie_q, tie_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic                 seen_a_q, seen_a_d, seen_b_q, seen_b_d;
  logic                 tout_q, tout_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [CLR_W-1:0]     clr_q, clr_d;
  logic                 cnt_en, cnt_clr, resp_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      resp_q   <= '0;
      tie_q    <= '0;
      err_q    <= 1'b0;
      cap_a_q  <= '0;
      cap_b_q  <= '0;
      seen_a_q <= 1'b0;
      seen_b_q <= 1'b0;
      tout_q   <= 1'b0;
      tmr_q    <= '0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      resp_q   <= resp_d;
      tie_q    <= tie_d;
      err_q    <= err_d;
      cap_a_q  <= cap_a_d;
      cap_b_q  <= cap_b_d;
      seen_a_q <= seen_a_d;
      seen_b_q <= seen_b_d;
      tout_q   <= tout_d;
      tmr_q    <= tmr_d;
      clr_q    <= clr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    resp_d   = resp_q;
    tie_d    = tie_q;
    err_d    = err_q;
    cap_a_d  = cap_a_q;
    cap_b_d  = cap_b_q;
    seen_a_d = seen_a_q;
    seen_b_d = seen_b_q;
    tout_d   = tout_q;
    tmr_d    = tmr_q;
    clr_d    = clr_q;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    resp_bit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          sel_d   = '0;
          resp_d  = '0;
          tie_d   = '0;
          err_d   = 1'b0;
          clr_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_clr  = 1'b1;
        seen_a_d = 1'b0;
        seen_b_d = 1'b0;
        tout_d   = 1'b0;
        tmr_d    = '0;
        if (clr_q == CLR_LAST) begin
          state_d = S_COUNT;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end
      S_COUNT: begin
        cnt_en = 1'b1;
        tmr_d  = tmr_q + TMR_W'(1);
        // Only the first finished pulse per side is captured; later count drift is ignored.
        if (fin_a_i && !seen_a_q) begin
          cap_a_d  = cnt_a_i;
          seen_a_d = 1'b1;
        end
        if (fin_b_i && !seen_b_q) begin
          cap_b_d  = cnt_b_i;
          seen_b_d = 1'b1;
        end
        if ((seen_a_q || fin_a_i) && (seen_b_q || fin_b_i)) begin
          state_d = S_COMPARE;
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_COMPARE;
          tout_d  = 1'b1;
        end
      end
      S_COMPARE: begin
        if (tout_q) begin
          err_d = 1'b1;
        end else begin
          resp_bit = (cap_a_q > cap_b_q);
          if (cap_a_q == cap_b_q) tie_d = tie_q + TIE_W'(1);
        end
        resp_d  = {resp_q[RESP_BITS-2:0], resp_bit};
        state_d = (sel_q == LAST_IDX) ? S_DONE : S_NEXT;
      end
      S_NEXT: begin
        sel_d   = sel_q + IDX_W'(1);
        clr_d   = '0;
        state_d = S_CLEAR;
      end
      S_DONE: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_en_o     = cnt_en;
  assign cnt_clr_o    = cnt_clr;
  assign sel_idx_o    = sel_q;
  assign busy_o       = (state_q != S_IDLE);
  assign resp_o       = resp_q;
  assign resp_valid_o = (state_q == S_DONE);
  assign tie_cnt_o    = tie_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: a per-pair counter model feeds the DUT, and each
// response is checked against a bit-by-bit model built from the pair configuration.
module tb_puf_response_collector;
  localparam int TO = 64;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, resp_ready = 1'b1;
  logic [7:0] cnt_a = 8'd0, cnt_b = 8'd0;
  logic       fin_a = 1'b0, fin_b = 1'b0;
  logic       cnt_en, cnt_clr, busy, resp_valid, err;
  logic [2:0] sel;
  logic [7:0] resp;
  logic [3:0] tie;

  int n_cmp = 0, n_bad = 0;

  puf_response_collector #(.CNT_W(8), .RESP_BITS(8), .CLR_CYC(2), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .cnt_a_i(cnt_a), .cnt_b_i(cnt_b), .fin_a_i(fin_a), .fin_b_i(fin_b),
    .cnt_en_o(cnt_en), .cnt_clr_o(cnt_clr), .sel_idx_o(sel), .busy_o(busy),
    .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .tie_cnt_o(tie), .err_o(err)
  );

  always #5 clk = ~clk;

  // Per RO pair: value before/at finish, value after finish (drift), finish cycle, never-finish.
  int cfg_va[8], cfg_vb[8], cfg_xa[8], cfg_xb[8], cfg_da[8], cfg_db[8];
  bit cfg_na[8], cfg_nb[8];
  int clr_n[8], en_n[8];
  int sel_log[$];
  int sel_bad = 0, cyc = 0, cur_sel = 0;
  bit prev_clr = 1'b0;

  // Counter model and observer; updates land on the falling edge, DUT samples on the rising.
  always @(negedge clk) begin
    int s;
    s = int'(sel);
    if (cnt_clr) cyc = 0;
    else if (cnt_en) cyc = cyc + 1;
    fin_a = !cfg_na[s] && (cyc >= cfg_da[s]);
    fin_b = !cfg_nb[s] && (cyc >= cfg_db[s]);
    cnt_a = 8'((cyc > cfg_da[s]) ? cfg_xa[s] : cfg_va[s]);
    cnt_b = 8'((cyc > cfg_db[s]) ? cfg_xb[s] : cfg_vb[s]);
    if (cnt_clr) begin
      clr_n[s] = clr_n[s] + 1;
      if (!prev_clr) begin
        sel_log.push_back(s);
        cur_sel = s;
      end
    end
    if (cnt_en) en_n[s] = en_n[s] + 1;
    if ((cnt_clr || cnt_en) && s != cur_sel) sel_bad = sel_bad + 1;
    prev_clr = cnt_clr;
  end

  function automatic bit pair_timeout(input int i);
    return cfg_na[i] || cfg_nb[i] || cfg_da[i] > TO || cfg_db[i] > TO;
  endfunction

  function automatic int exp_count_cycles(input int i);
    if (pair_timeout(i)) return TO;
    return (cfg_da[i] > cfg_db[i]) ? cfg_da[i] : cfg_db[i];
  endfunction

  function automatic void ref_model(output logic [7:0] r, output int t, output bit e);
    r = 8'h00; t = 0; e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit b;
      b = 1'b0;
      if (pair_timeout(i)) e = 1'b1;
      else begin
        b = (cfg_va[i] > cfg_vb[i]);
        if (cfg_va[i] == cfg_vb[i]) t++;
      end
      r = {r[6:0], b};
    end
  endfunction

  task automatic set_pattern();
    for (int i = 0; i < 8; i++) begin
      cfg_va[i] = (i % 2 == 0) ? 200 : 100;
      cfg_vb[i] = (i % 2 == 0) ? 100 : 200;
      cfg_xa[i] = cfg_va[i]; cfg_xb[i] = cfg_vb[i];
      cfg_da[i] = 40; cfg_db[i] = 40;
      cfg_na[i] = 1'b0; cfg_nb[i] = 1'b0;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < 8; i++) begin
      cfg_va[i] = int'($urandom_range(0, 255));
      cfg_vb[i] = ($urandom_range(0, 3) == 0) ? cfg_va[i] : int'($urandom_range(0, 255));
      cfg_xa[i] = int'($urandom_range(0, 255));
      cfg_xb[i] = int'($urandom_range(0, 255));
      cfg_da[i] = int'($urandom_range(1, 60));
      cfg_db[i] = int'($urandom_range(1, 60));
      cfg_na[i] = ($urandom_range(0, 15) == 0);
      cfg_nb[i] = ($urandom_range(0, 15) == 0);
    end
  endtask

  // Starts one evaluation and returns once resp_valid is seen (or the cycle budget expires).
  task automatic do_eval(output bit timed_out);
    int n;
    for (int i = 0; i < 8; i++) begin clr_n[i] = 0; en_n[i] = 0; end
    sel_log.delete();
    sel_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!resp_valid && n < 3000) begin @(negedge clk); n++; end
    timed_out = !resp_valid;
  endtask

  task automatic check_result(input string tag, input bit to);
    logic [7:0] er; int et; bit ee;
    ref_model(er, et, ee);
    n_cmp++; if (to) begin n_bad++; $display("FAIL %s_done: resp_valid never rose", tag); end
    n_cmp++; if (resp !== er) begin n_bad++; $display("FAIL %s_resp: got %h expected %h", tag, resp, er); end
    n_cmp++; if (tie !== 4'(et)) begin n_bad++; $display("FAIL %s_tie: got %0d expected %0d", tag, tie, et); end
    n_cmp++; if (err !== ee) begin n_bad++; $display("FAIL %s_err: got %b expected %b", tag, err, ee); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (en_n[i] != exp_count_cycles(i) || clr_n[i] != 2) begin
        n_bad++;
        $display("FAIL %s_bit%0d_timing: count %0d clear %0d expected count %0d clear 2",
                 tag, i, en_n[i], clr_n[i], exp_count_cycles(i));
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, cnt_en, cnt_clr, resp_valid, err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, cnt_en, cnt_clr, resp_valid, err}); end
    n_cmp++; if ({sel, resp, tie} !== 15'b0) begin
      n_bad++; $display("FAIL reset_data: sel %0d resp %h tie %0d expected all 0", sel, resp, tie); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored: busy %b expected 0", busy); end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_pattern();
    bit to;
    set_pattern();
    do_eval(to);
    check_result("pattern", to);
    n_cmp++; if (resp !== 8'hAA) begin n_bad++; $display("FAIL pattern_aa: got %h expected aa", resp); end
    n_cmp++; if (sel_log.size() != 8 || sel_bad != 0) begin
      n_bad++; $display("FAIL pattern_sel: %0d visits %0d unstable expected 8 visits 0 unstable", sel_log.size(), sel_bad); end
    for (int i = 0; i < sel_log.size(); i++) begin
      n_cmp++; if (sel_log[i] != i) begin n_bad++; $display("FAIL pattern_sel_order%0d: got %0d expected %0d", i, sel_log[i], i); end
    end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp !== 8'hAA) begin
      n_bad++; $display("FAIL pattern_idle: valid %b busy %b resp %h expected 0 0 aa", resp_valid, busy, resp); end
  endtask

  task automatic test_tie();
    bit to;
    set_pattern();
    cfg_va[3] = 150; cfg_vb[3] = 150; cfg_xa[3] = 150; cfg_xb[3] = 150;
    do_eval(to);
    check_result("tie", to);
    n_cmp++; if (tie !== 4'd1) begin n_bad++; $display("FAIL tie_one: got %0d expected 1", tie); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit to;
    set_pattern();
    cfg_nb[0] = 1'b1;
    do_eval(to);
    check_result("timeout", to);
    n_cmp++; if (resp !== 8'h2A || err !== 1'b1 || en_n[0] != TO) begin
      n_bad++; $display("FAIL timeout_bit0: resp %h err %b count %0d expected 2a 1 %0d", resp, err, en_n[0], TO); end
    @(negedge clk);
  endtask

  task automatic test_skew();
    bit to;
    set_pattern();
    cfg_da[0] = 10; cfg_va[0] = 90; cfg_xa[0] = 250;
    cfg_db[0] = 30; cfg_vb[0] = 120; cfg_xb[0] = 120;
    cfg_da[2] = TO; cfg_db[2] = TO;
    do_eval(to);
    check_result("skew", to);
    n_cmp++; if (resp !== 8'h2A || err !== 1'b0) begin
      n_bad++; $display("FAIL skew_word: resp %h err %b expected 2a 0", resp, err); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit to;
    for (int k = 0; k < 4; k++) begin
      set_random();
      do_eval(to);
      check_result($sformatf("random%0d", k), to);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit to; int bad; logic [7:0] er; int et; bit ee;
    set_random();
    ref_model(er, et, ee);
    resp_ready = 1'b0;
    do_eval(to);
    check_result("hold", to);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      start = k[0];
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp !== er || cnt_clr !== 1'b0 || cnt_en !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_stable: %0d unstable cycles expected 0", bad); end
    resp_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: valid %b busy %b expected 0 0", resp_valid, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || resp !== er) begin
      n_bad++; $display("FAIL hold_no_restart: busy %b resp %h expected 0 %h", busy, resp, er); end
    set_random();
    do_eval(to);
    check_result("fresh", to);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit to; int n;
    set_pattern();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(sel == 3'd4 && cnt_en) && n < 2000) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 2000) begin n_bad++; $display("FAIL midreset_reach: idx4 count phase never seen"); end
    rst_n = 1'b0; start = 1'b1;
    #1;
    n_cmp++; if ({busy, cnt_en, cnt_clr, resp_valid, err, sel, resp, tie} !== 20'b0) begin
      n_bad++; $display("FAIL midreset_zero: busy %b en %b clr %b sel %0d resp %h tie %0d expected all 0",
                        busy, cnt_en, cnt_clr, sel, resp, tie); end
    repeat (3) @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: busy %b expected 0", busy); end
    set_random();
    do_eval(to);
    check_result("after_reset", to);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      cfg_va[i] = 0; cfg_vb[i] = 0; cfg_xa[i] = 0; cfg_xb[i] = 0;
      cfg_da[i] = 1; cfg_db[i] = 1; cfg_na[i] = 1'b0; cfg_nb[i] = 1'b0;
      clr_n[i] = 0; en_n[i] = 0;
    end
    test_reset();
    test_pattern();
    test_tie();
    test_timeout();
    test_skew();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
